// File: rtl/draw_pkg.sv
// draw_pkg: shared framebuffer geometry defaults, draw mode and state encodings.
package draw_pkg;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int ADDR_W   = 19;
  localparam int COLOR_W  = 3;
  localparam logic [1:0] MODE_DRAW  = 2'd0;
  localparam logic [1:0] MODE_ERASE = 2'd1;
  localparam logic [1:0] MODE_FILL  = 2'd2;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
endpackage

// File: rtl/pixel_addr_gen.sv
// pixel_addr_gen: clips a signed pixel coordinate to the screen and forms its linear address.
module pixel_addr_gen #(
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int ADDR_W   = draw_pkg::ADDR_W
) (
  input  logic signed [11:0] px,
  input  logic signed [10:0] py,
  output logic               in_bounds,
  output logic [ADDR_W-1:0]  addr
);
  logic [ADDR_W-1:0] x, y, row_base;
  assign in_bounds = !px[11] && !py[10] && px[10:0] < 11'(SCREEN_W) && py[9:0] < 10'(SCREEN_H);
  assign x = ADDR_W'(px[10:0]);
  assign y = ADDR_W'(py[9:0]);
  // 640 = 512 + 128, so the row base needs no multiplier
  assign row_base = (SCREEN_W == 640) ? (y << 9) + (y << 7) : ADDR_W'(y * SCREEN_W);
  assign addr = row_base + x;
endmodule

// File: rtl/sprite_draw_engine.sv
// sprite_draw_engine: scans an SPR_W x SPR_H sprite at a signed anchor and issues
// one framebuffer write per visible, on-screen pixel, honouring write back-pressure.
module sprite_draw_engine #(
  parameter int SCREEN_W = draw_pkg::SCREEN_W,
  parameter int SCREEN_H = draw_pkg::SCREEN_H,
  parameter int ADDR_W   = draw_pkg::ADDR_W,
  parameter int COLOR_W  = draw_pkg::COLOR_W,
  parameter int SPR_W    = 8,
  parameter int SPR_H    = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic [10:0]            anchor_x,
  input  logic [9:0]             anchor_y,
  input  logic [COLOR_W-1:0]     color,
  input  logic [SPR_W*SPR_H-1:0] mask,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      mem_waddr,
  output logic [COLOR_W-1:0]     mem_wdata,
  output logic                   mem_wenable,
  input  logic                   mem_wready
);
  import draw_pkg::*;
  localparam int N  = SPR_W * SPR_H;
  localparam int CW = SPR_W > 1 ? $clog2(SPR_W) : 1;
  localparam int RW = SPR_H > 1 ? $clog2(SPR_H) : 1;
  localparam int IW = N > 1 ? $clog2(N) : 1;
  state_t state, state_n;
  logic [1:0]         mode_q;
  logic [10:0]        ax_q;
  logic [9:0]         ay_q;
  logic [COLOR_W-1:0] color_q;
  logic [N-1:0]       mask_q;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic               fin, stall, last, in_bounds, visible;
  logic [11:0]        px;
  logic [10:0]        py;
  logic [IW-1:0]      idx;
  logic [ADDR_W-1:0]  addr;
  assign stall   = mem_wenable && !mem_wready;
  assign last    = col == CW'(SPR_W - 1) && row == RW'(SPR_H - 1);
  assign px      = {ax_q[10], ax_q} + 12'(col);
  assign py      = {ay_q[9], ay_q} + 11'(row);
  assign idx     = IW'(row * SPR_W + col);
  assign visible = (mode_q[1] || mask_q[idx]) && in_bounds;
  pixel_addr_gen #(.SCREEN_W(SCREEN_W), .SCREEN_H(SCREEN_H), .ADDR_W(ADDR_W)) addr_gen (
    .px(px), .py(py), .in_bounds(in_bounds), .addr(addr)
  );
  always_ff @(negedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  // fin marks that the last candidate has been issued; SCAN ends once it is accepted
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && start) ? SCAN :
              (state == SCAN && fin && !stall) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(negedge clock or posedge reset) begin
    if (reset) begin
      {mode_q, ax_q, ay_q, color_q, mask_q} <= '0;
      {col, row, fin, busy, done} <= '0;
      {mem_waddr, mem_wdata, mem_wenable} <= '0;
    end else begin
      done <= state == SCAN && state_n == DONE;
      busy <= state_n != IDLE;
      if (state == IDLE && start) begin
        {mode_q, ax_q, ay_q, color_q, mask_q} <= {mode, anchor_x, anchor_y, color, mask};
        {col, row, fin} <= '0;
      end
      if (state == SCAN && !stall) begin
        if (fin) mem_wenable <= 1'b0;
        else begin
          mem_wenable <= visible;
          mem_waddr   <= addr;
          mem_wdata   <= (mode_q == MODE_ERASE) ? '0 : color_q;
          fin         <= last;
          col         <= (col == CW'(SPR_W - 1)) ? '0 : col + 1'b1;
          row         <= (col == CW'(SPR_W - 1)) ? row + 1'b1 : row;
        end
      end
    end
  end
endmodule

// File: tb/tb_sprite_draw_engine.sv
// tb_sprite_draw_engine: directed sprite draws with a write scoreboard checked by a
// monitor on the rising edge, away from the falling edge the DUT updates on.
module tb_sprite_draw_engine;
  import draw_pkg::*;
  logic        clock = 1'b0, reset = 1'b1, start = 1'b0, mem_wready = 1'b1;
  logic [1:0]  mode = '0;
  logic [10:0] anchor_x = '0;
  logic [9:0]  anchor_y = '0;
  logic [2:0]  color = '0;
  logic [63:0] mask = '0;
  logic        busy, done, mem_wenable;
  logic [18:0] mem_waddr;
  logic [2:0]  mem_wdata;
  int          vectors = 0, miscompares = 0, wr_cnt = 0, first_addr = 0, last_addr = 0;
  bit          first_seen = 1'b0, held = 1'b0;
  logic [18:0] h_addr;
  logic [2:0]  h_data;
  logic [21:0] exp_q[$];

  sprite_draw_engine dut (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .anchor_x(anchor_x),
    .anchor_y(anchor_y), .color(color), .mask(mask), .busy(busy), .done(done),
    .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wenable(mem_wenable),
    .mem_wready(mem_wready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // monitor: a write transfers on the falling edge, so the rising edge before it sees it stably
  always @(posedge clock) begin
    if (reset) held = 1'b0;
    else begin
      if (held) begin
        chk("stall_hold_addr", int'(mem_waddr), int'(h_addr));
        chk("stall_hold_data", int'(mem_wdata), int'(h_data));
        chk("stall_hold_en", int'(mem_wenable), 1);
      end
      held = mem_wenable && !mem_wready;
      h_addr = mem_waddr;
      h_data = mem_wdata;
      if (mem_wenable && mem_wready) begin
        wr_cnt++;
        if (!first_seen) begin
          first_seen = 1'b1;
          first_addr = int'(mem_waddr);
        end
        last_addr = int'(mem_waddr);
        if (exp_q.size() == 0) chk("unexpected_write_addr", int'(mem_waddr), -1);
        else begin
          logic [21:0] e;
          e = exp_q.pop_front();
          chk("waddr", int'(mem_waddr), int'(e[21:3]));
          chk("wdata", int'(mem_wdata), int'(e[2:0]));
        end
      end
    end
  end

  task automatic launch(input logic [1:0] m, input int ax, input int ay, input logic [2:0] c,
                        input logic [63:0] mk);
    for (int r = 0; r < 8; r++)
      for (int cc = 0; cc < 8; cc++) begin
        int px, py;
        px = ax + cc;
        py = ay + r;
        if ((m >= 2'd2 || mk[6'(r * 8 + cc)]) && px >= 0 && px < 640 && py >= 0 && py < 480)
          exp_q.push_back({19'(py * 640 + px), (m == MODE_ERASE) ? 3'd0 : c});
      end
    first_seen = 1'b0;
    mode = m;
    anchor_x = 11'(ax);
    anchor_y = 10'(ay);
    color = c;
    mask = mk;
    mem_wready = 1'b1;
    start = 1'b1;
    @(negedge clock);
    #1 start = 1'b0;
  endtask

  task automatic run(input logic [1:0] m, input int ax, input int ay, input logic [2:0] c,
                     input logic [63:0] mk, input bit tog, input bit pulses, input int exp_lat,
                     input string tag);
    int n, dn;
    launch(m, ax, ay, c, mk);
    chk({tag, "_busy"}, int'(busy), 1);
    n = 0;
    while (n < 2000) begin
      @(negedge clock);
      n++;
      #1;
      if (tog) mem_wready = ~n[0];
      start = pulses && n == 20;
      if (pulses && n == 20) anchor_x = '0;
      if (done) break;
    end
    start = 1'b0;
    mem_wready = 1'b1;
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_drained"}, exp_q.size(), 0);
    if (pulses) begin
      start = 1'b1;
      @(negedge clock);
      #1 start = 1'b0;
      dn = 0;
      repeat (80) begin
        @(negedge clock);
        #1 dn += int'(done);
      end
      chk({tag, "_second_done"}, dn, 0);
      chk({tag, "_idle_busy"}, int'(busy), 0);
    end else begin
      @(negedge clock);
      #1;
      chk({tag, "_done_pulse"}, int'(done), 0);
      chk({tag, "_idle_busy"}, int'(busy), 0);
    end
  endtask

  initial begin
    logic [63:0] cb;
    int base, n;
    #3;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_wen", int'(mem_wenable), 0);
    chk("rst_waddr", int'(mem_waddr), 0);
    chk("rst_wdata", int'(mem_wdata), 0);
    @(negedge clock);
    #1 reset = 1'b0;

    base = wr_cnt;
    run(MODE_DRAW, 10, 20, 3'b101, '1, 1'b0, 1'b0, 65, "draw");
    chk("draw_writes", wr_cnt - base, 64);
    chk("draw_first", first_addr, 12810);
    chk("draw_last", last_addr, 17297);

    for (int i = 0; i < 64; i++) cb[i] = ((i / 8 + i % 8) % 2) == 0;
    base = wr_cnt;
    run(MODE_ERASE, 0, 0, 3'b111, cb, 1'b0, 1'b0, 65, "erase");
    chk("erase_writes", wr_cnt - base, 32);

    base = wr_cnt;
    run(MODE_FILL, -3, 476, 3'b010, '0, 1'b0, 1'b0, 65, "clip");
    chk("clip_writes", wr_cnt - base, 20);
    chk("clip_first", first_addr, 304640);

    base = wr_cnt;
    run(2'd3, 636, -2, 3'b011, '0, 1'b0, 1'b0, 65, "rsvd");
    chk("rsvd_writes", wr_cnt - base, 24);

    base = wr_cnt;
    run(MODE_DRAW, 100, 50, 3'b111, '1, 1'b1, 1'b0, 129, "bp");
    chk("bp_writes", wr_cnt - base, 64);

    launch(MODE_DRAW, 0, 0, 3'b100, '1);
    base = wr_cnt;
    n = 0;
    while (wr_cnt - base < 17 && n < 500) begin
      @(posedge clock);
      #1 n++;
    end
    chk("rst17_reached", wr_cnt - base, 17);
    reset = 1'b1;
    #1;
    chk("rst17_busy", int'(busy), 0);
    chk("rst17_done", int'(done), 0);
    chk("rst17_wen", int'(mem_wenable), 0);
    chk("rst17_waddr", int'(mem_waddr), 0);
    chk("rst17_wdata", int'(mem_wdata), 0);
    exp_q.delete();
    @(negedge clock);
    #1 reset = 1'b0;
    base = wr_cnt;
    run(MODE_DRAW, 0, 0, 3'b100, '1, 1'b0, 1'b0, 65, "redraw");
    chk("redraw_writes", wr_cnt - base, 64);
    chk("redraw_first", first_addr, 0);

    base = wr_cnt;
    run(MODE_DRAW, 636, 200, 3'b110, 64'h0123456789ABCDEF, 1'b0, 1'b1, 65, "pulse");
    chk("pulse_first", first_addr, 128000 + 636);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/sprite_draw_engine.md
# sprite_draw_engine

Parametrised framebuffer sprite writer, the general successor to the fixed 3×3 glyph drawer. On a start request it scans an SPR_W×SPR_H bitmask anchored at a signed screen coordinate and issues one framebuffer write per visible, in-bounds pixel. It runs one pixel per cycle, with back-pressure from the framebuffer write port. It sits between game/object logic and the dual-port VGA framebuffer, sharing that framebuffer's write port.

## Interface
- SCREEN_W, 640, framebuffer width in pixels
- SCREEN_H, 480, framebuffer height in pixels
- ADDR_W, 19, framebuffer address width
- COLOR_W, 3, pixel colour width
- SPR_W, 8, sprite width (1..32)
- SPR_H, 8, sprite height (1..32)
- clock  in  1  single clock; all state updates on its negative edge
- reset  in  1  asynchronous, active-high
- start  in  1  draw request; sampled only in IDLE
- mode  in  2  0 = DRAW (mask, colour), 1 = ERASE (mask, colour 0), 2 = FILL (whole rect, colour), 3 = reserved (treated as FILL)
- anchor_x  in  11  signed top-left x
- anchor_y  in  10  signed top-left y
- color  in  COLOR_W  draw colour
- mask  in  SPR_W*SPR_H  bit r*SPR_W+c = pixel (c,r) visible
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final pixel
- mem_waddr  out  ADDR_W  linear address y*SCREEN_W+x
- mem_wdata  out  COLOR_W  pixel value
- mem_wenable  out  1  write valid
- mem_wready  in  1  framebuffer accepts write this edge

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: start=1 latches mode, anchor, color and mask. It clears col/row counters and moves to SCAN. start while busy is ignored; no queueing.
- SCAN: each unstalled cycle evaluates candidate (c,r) in row-major order (c fastest):
  - px = anchor_x + c, py = anchor_y + r, computed signed with 12/11-bit intermediates.
  - Write condition: (mode==FILL or mask bit set) and 0 ≤ px < SCREEN_W and 0 ≤ py < SCREEN_H.
  - If the write condition holds: mem_wenable=1, mem_waddr=py*SCREEN_W+px (truncated to ADDR_W), and mem_wdata=color, or 0 in ERASE.
  - Otherwise: mem_wenable=0; the candidate is skipped and consumes one cycle.
- Stall: while mem_wenable=1 and mem_wready=0, mem_waddr, mem_wdata, mem_wenable and the counters all hold.
- After candidate (SPR_W-1, SPR_H-1) is issued and accepted (or skipped), move to DONE with mem_wenable=0.
- DONE: done=1 for one cycle, then IDLE. busy=0 in IDLE only.
- Reset (any time, including mid-SCAN): state IDLE, counters 0, mem_wenable=0, mem_waddr=0, mem_wdata=0, busy=0, done=0. Any partially drawn sprite is left as is.
- Multiply by SCREEN_W is by constant; 640 is implemented as (py<<9)+(py<<7).

## Timing
- All outputs registered.
- First possible write is presented on the edge after the start edge.
- Unstalled draw: exactly SPR_W*SPR_H SCAN cycles, then done on the next cycle. Start-to-done latency is SPR_W*SPR_H+1 edges plus stall cycles.
- A write is transferred on an edge where mem_wenable=1 and mem_wready=1.
- mem_wready is ignored when mem_wenable=0.
- start asserted in the DONE cycle is ignored; start asserted in the following IDLE cycle is accepted.

## Structure
- Shared package draw_pkg holds:
  - SCREEN_W, SCREEN_H, ADDR_W and COLOR_W defaults
  - the mode encoding (MODE_DRAW, MODE_ERASE, MODE_FILL)
  - the state encoding
- One sub-module, pixel_addr_gen, is combinational. It takes signed px/py and produces in_bounds and the linear address. It is reused by future line/rect drawers.
- The FSM, counters and output registers stay in sprite_draw_engine.

## Test plan
- DRAW 8×8, anchor (10,20), mask all ones, color 3'b101, mem_wready=1: 64 writes with addresses 12810..12817, 13450..13457, …, 17290..17297, data 5; done on the 65th edge after start.
- Checkerboard mask, ERASE, anchor (0,0): exactly 32 writes, all data 0, only at addresses where bit r*8+c is set.
- Clipping, FILL, anchor (-3,476): only c≥3 and r≤3 are written, giving 20 writes. First address is 476*640+0 = 304640. Busy still lasts 64 cycles.
- Back-pressure: mem_wready toggles 1/0 each cycle during DRAW of a full mask. Outputs hold while stalled, no write is duplicated or dropped, and latency is 128+1.
- Reset asserted at write 17 of 64: all outputs 0 within the same cycle (async). A subsequent start draws a full 64 writes from (0,0) of the sprite.
- start pulsed mid-SCAN and in the DONE cycle: no effect on the write sequence and no second done.
